dtree_seq_walker: RTL and testbench
===================================

Name: dtree_seq_walker

Overview:
- Programmable, sequential successor to the fixed combinational mammographic decision trees.
- Stores an N_NODES-entry node table written over a config port. Each sample is walked from the root one node per clock, comparing the top PREC bits of the selected feature against the node's threshold.
- Sits between the feature-quantiser stream and the class-result consumer. Valid/ready handshakes are on both sides.
- Adds runtime-loadable trees, depth-limit error detection, backpressure and a classified-sample counter.

Parameters:
- N_FEAT, 5, number of input features.
- FEAT_W, 8, width of each feature.
- PREC, 2, number of feature MSBs compared (compared slice is feature[FEAT_W-1:FEAT_W-PREC]); 1..FEAT_W.
- N_NODES, 64, node-table depth.
- NODE_AW, 6, node address width; must satisfy 2^NODE_AW >= N_NODES.
- CLASS_W, 2, class label width; must be <= NODE_W.
- MAX_DEPTH, 16, maximum number of internal nodes visited before the walk is aborted.
- Derived values:
  - FIDX_W = max(1, clog2(N_FEAT)).
  - NODE_W = 1 + FIDX_W + PREC + 2*NODE_AW, which is 18 at the defaults.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NODE_AW  node index to write.
- cfg_wdata  in  NODE_W  node word.
- cfg_drop  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  sample valid.
- in_ready  out  1  walker can accept a sample.
- in_feat  in  N_FEAT*FEAT_W  packed features; feature i is at bits [i*FEAT_W +: FEAT_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  CLASS_W  predicted class.
- out_err  out  1  walk aborted (depth limit reached or bad pointer).
- out_count  out  16  number of results handed off; saturates at 0xFFFF.

Behaviour:
- Node word layout, MSB to LSB:
  - leaf (1 bit).
  - feat_idx (FIDX_W bits).
  - thr (PREC bits).
  - left (NODE_AW bits).
  - right (NODE_AW bits).
  - For a leaf, the class is cfg_wdata[CLASS_W-1:0] and all other fields are ignored.
- Node table: register array, read combinationally, not cleared by reset.
- Config writes:
  - Accepted only in IDLE with cfg_addr < N_NODES.
  - Otherwise the write is dropped and cfg_drop pulses high for 1 cycle.
- State machine: IDLE, WALK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_feat, set node = 0 and depth = 0, go to WALK.
- WALK: one node evaluated per cycle.
  - Leaf: capture its class, err = 0, go to DONE.
  - feat_idx >= N_FEAT, or selected child >= N_NODES: class = 0, err = 1, go to DONE.
  - Otherwise: if slice <= thr (unsigned) then node = left, else node = right; depth increments.
  - If depth reaches MAX_DEPTH with no leaf found: class = 0, err = 1, go to DONE.
- DONE:
  - out_valid = 1; out_class and out_err are held stable until out_ready.
  - On out_valid & out_ready: out_count increments (saturating), go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency: a sample accepted at edge t0 whose leaf lies at depth d (root = depth 0) has out_valid high from cycle t0+2+d. Minimum latency is 2 cycles.
- Throughput: one sample per d+3 cycles with out_ready tied high.
- in_feat changes while in WALK or DONE have no effect.
- Reset:
  - Any state returns to IDLE next edge and any walk in progress is discarded.
  - out_valid = 0, out_class = 0, out_err = 0, out_count = 0, cfg_drop = 0.
  - in_ready = 0 while rst is high, 1 in the first cycle after.
- A cfg_we and an in_valid accepted in the same IDLE cycle are both honoured. The write lands on that edge; the walk starts the next cycle and reads the new contents.

Test Plan:
- Reproduce the depth-1 tree.
  - Load: node0 = {leaf0, feat0, thr0, L=1, R=2}; node1 = leaf class 1; node2 = leaf class 0.
  - X0 = 0x3F gives class 1 and X0 = 0x40 gives class 0, each with out_err = 0 and out_valid 3 cycles after acceptance.
- Threshold equality, PREC = 2, thr = 1.
  - feature 0x7F (slice 1) goes left; 0x80 (slice 2) goes right.
- Depth abort: load an all-internal self-loop at node0 (L = R = 0).
  - Result is out_err = 1, out_class = 0, and out_valid MAX_DEPTH+1 cycles after acceptance.
- Backpressure: hold out_ready = 0 for 10 cycles.
  - out_class and out_valid stay stable and in_ready stays 0.
  - Release gives a single hand-off: out_count goes 0→1 and in_ready rises the next cycle.
- Config guards:
  - cfg_we during WALK gives a cfg_drop pulse and the table is unchanged.
  - cfg_addr = N_NODES in IDLE gives a cfg_drop pulse.
  - Bad child pointer 63 with N_NODES = 40 gives out_err = 1.
- Reset mid-WALK at depth 3: next cycle is IDLE with out_valid = 0 and out_count = 0, and the table contents are retained.

Source files
------------

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree walker: a runtime-loadable node table is walked
// from the root one node per clock. Each internal node compares the top PREC
// bits of one feature against its threshold. Samples enter and results leave
// over valid/ready handshakes.
module dtree_seq_walker #(
  parameter  int unsigned N_FEAT    = 5,
  parameter  int unsigned FEAT_W    = 8,
  parameter  int unsigned PREC      = 2,
  parameter  int unsigned N_NODES   = 64,
  parameter  int unsigned NODE_AW   = 6,
  parameter  int unsigned CLASS_W   = 2,
  parameter  int unsigned MAX_DEPTH = 16,
  localparam int unsigned FIDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
  localparam int unsigned NODE_W    = 1 + FIDX_W + PREC + 2 * NODE_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [NODE_AW-1:0]         cfg_addr,
  input  logic [NODE_W-1:0]          cfg_wdata,
  output logic                       cfg_drop,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]   in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       out_err,
  output logic [15:0]                out_count
);

  localparam int unsigned DEPTH_W = (MAX_DEPTH > 2) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(MAX_DEPTH - 1);

  localparam int unsigned LEAF_B  = NODE_W - 1;
  localparam int unsigned FIDX_LO = PREC + 2 * NODE_AW;
  localparam int unsigned THR_LO  = 2 * NODE_AW;
  localparam int unsigned LEFT_LO = NODE_AW;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t                    r_state;
  logic [NODE_W-1:0]         r_table [N_NODES];
  logic [N_FEAT*FEAT_W-1:0]  r_feat;
  logic [NODE_AW-1:0]        r_node;
  logic [DEPTH_W-1:0]        r_depth;
  logic                      r_out_valid;
  logic [CLASS_W-1:0]        r_out_class;
  logic                      r_out_err;
  logic [15:0]               r_out_count;
  logic                      r_cfg_drop;

  logic [NODE_W-1:0]         w_word;
  logic                      w_leaf;
  logic [FIDX_W-1:0]         w_fidx;
  logic [PREC-1:0]           w_thr;
  logic [NODE_AW-1:0]        w_left;
  logic [NODE_AW-1:0]        w_right;
  logic [PREC-1:0]           w_slice;
  logic                      w_fidx_ok;
  logic [NODE_AW-1:0]        w_child;
  logic                      w_child_ok;
  logic                      w_cfg_ok;
  logic                      w_unused_feat;

  assign w_word  = r_table[r_node];
  assign w_leaf  = w_word[LEAF_B];
  assign w_fidx  = w_word[FIDX_LO +: FIDX_W];
  assign w_thr   = w_word[THR_LO +: PREC];
  assign w_left  = w_word[LEFT_LO +: NODE_AW];
  assign w_right = w_word[0 +: NODE_AW];

  // Only the top PREC bits of each feature take part in comparisons.
  assign w_unused_feat = ^r_feat;

  // Select the compared slice of the addressed feature; flag out-of-range index
  always_comb begin
    w_slice   = '0;
    w_fidx_ok = 1'b0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (w_fidx == FIDX_W'(i)) begin
        w_slice   = r_feat[i*FEAT_W + FEAT_W - PREC +: PREC];
        w_fidx_ok = 1'b1;
      end
    end
  end

  assign w_child    = (w_slice <= w_thr) ? w_left : w_right;
  assign w_child_ok = (32'(w_child) < N_NODES);

  assign w_cfg_ok = cfg_we && !rst && (r_state == S_IDLE) && (32'(cfg_addr) < N_NODES);

  // Node table: write-only from the config port, survives reset
  always_ff @(posedge clk) begin
    if (w_cfg_ok) r_table[cfg_addr] <= cfg_wdata;
  end

  // Walker FSM with registered result, drop pulse and hand-off counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_node      <= '0;
      r_depth     <= '0;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
      r_out_count <= '0;
      r_cfg_drop  <= 1'b0;
    end else begin
      r_cfg_drop <= cfg_we && !w_cfg_ok;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_feat  <= in_feat;
            r_node  <= '0;
            r_depth <= '0;
            r_state <= S_WALK;
          end
        end
        S_WALK: begin
          if (w_leaf) begin
            r_out_class <= w_word[CLASS_W-1:0];
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (!w_fidx_ok || !w_child_ok || (r_depth == DEPTH_LAST)) begin
            // Abort on the MAX_DEPTH-th internal node rather than one cycle later
            r_out_class <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_node  <= w_child;
            r_depth <= r_depth + DEPTH_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_count != 16'hFFFF) r_out_count <= r_out_count + 16'd1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_err   = r_out_err;
  assign out_count = r_out_count;
  assign cfg_drop  = r_cfg_drop;

endmodule

// File: tb/tb_dtree_seq_walker.sv
// Directed bench for dtree_seq_walker: default instance plus a 40-node
// instance for address-range and child-pointer guards.
module tb_dtree_seq_walker;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // default instance
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [17:0] cfg_wdata;
  logic        cfg_drop;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic        out_err;
  logic [15:0] out_count;

  // 40-node instance
  logic        b_cfg_we;
  logic [5:0]  b_cfg_addr;
  logic [17:0] b_cfg_wdata;
  logic        b_cfg_drop;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [39:0] b_in_feat;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [1:0]  b_out_class;
  logic        b_out_err;
  logic [15:0] b_out_count;

  int n_checks = 0;
  int n_errors = 0;

  dtree_seq_walker u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_drop(cfg_drop),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_count(out_count)
  );

  dtree_seq_walker #(.N_NODES(40)) u_dut_small (
    .clk(clk), .rst(rst),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_wdata(b_cfg_wdata), .cfg_drop(b_cfg_drop),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_feat(b_in_feat),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class),
    .out_err(b_out_err), .out_count(b_out_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] mk_node(input logic [2:0] fidx, input logic [1:0] thr,
                                          input logic [5:0] l, input logic [5:0] r);
    return {1'b0, fidx, thr, l, r};
  endfunction

  function automatic logic [17:0] mk_leaf(input logic [1:0] cls);
    return {1'b1, 15'd0, cls};
  endfunction

  task automatic write_node(input logic [5:0] addr, input logic [17:0] data);
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
    check_eq("wr_nodrop", {31'd0, cfg_drop}, 32'd0);
  endtask

  task automatic start_sample(input logic [39:0] feat);
    check_eq("start_ready", {31'd0, in_ready}, 32'd1);
    in_feat  = feat;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // k0 = cycles already elapsed since the handshake cycle
  task automatic wait_result(input string tag, input int k0, input int exp_lat,
                             input logic [1:0] ecls, input logic eerr);
    int k = k0;
    while (!out_valid && k < 200) begin
      tick();
      k++;
    end
    check_eq({tag, "_lat"}, k, exp_lat);
    check_eq({tag, "_class"}, {30'd0, out_class}, {30'd0, ecls});
    check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, eerr});
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_sample(input string tag, input logic [39:0] feat, input int exp_lat,
                            input logic [1:0] ecls, input logic eerr);
    start_sample(feat);
    wait_result(tag, 1, exp_lat, ecls, eerr);
    handoff();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
    b_cfg_we = 1'b0; b_cfg_addr = '0; b_cfg_wdata = '0;
    b_in_valid = 1'b0; b_in_feat = '0; b_out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("post_rst_class", {30'd0, out_class}, 32'd0);
    check_eq("post_rst_err", {31'd0, out_err}, 32'd0);
    check_eq("post_rst_count", {16'd0, out_count}, 32'd0);
    check_eq("post_rst_drop", {31'd0, cfg_drop}, 32'd0);

    // depth-1 tree on feature 0, threshold 0
    write_node(6'd0, mk_node(3'd0, 2'd0, 6'd1, 6'd2));
    write_node(6'd1, mk_leaf(2'd1));
    write_node(6'd2, mk_leaf(2'd0));
    run_sample("d1_3f", 40'h00_0000_003F, 3, 2'd1, 1'b0);
    run_sample("d1_40", 40'h00_0000_0040, 3, 2'd0, 1'b0);
    check_eq("count_2", {16'd0, out_count}, 32'd2);

    // threshold equality, thr = 1
    write_node(6'd0, mk_node(3'd0, 2'd1, 6'd1, 6'd2));
    run_sample("thr_7f", 40'h00_0000_007F, 3, 2'd1, 1'b0);
    run_sample("thr_80", 40'h00_0000_0080, 3, 2'd0, 1'b0);

    // feature selection: feature 3, thr = 2
    write_node(6'd0, mk_node(3'd3, 2'd2, 6'd1, 6'd2));
    run_sample("f3_c0", 40'h00_C000_0000, 3, 2'd0, 1'b0);
    run_sample("f3_80", 40'h00_80FF_FFFF, 3, 2'd1, 1'b0);

    // leaf at root: minimum latency
    write_node(6'd0, mk_leaf(2'd3));
    run_sample("root_leaf", 40'h0, 2, 2'd3, 1'b0);

    // feature index out of range
    write_node(6'd0, mk_node(3'd5, 2'd0, 6'd1, 6'd2));
    run_sample("bad_fidx", 40'h0, 2, 2'd0, 1'b1);

    // self-loop: depth abort, with a config write attempted mid-walk
    write_node(6'd0, mk_node(3'd0, 2'd0, 6'd0, 6'd0));
    start_sample(40'h0);
    cfg_addr  = 6'd1;
    cfg_wdata = mk_leaf(2'd2);
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
    check_eq("walk_drop", {31'd0, cfg_drop}, 32'd1);
    tick();
    check_eq("walk_drop_end", {31'd0, cfg_drop}, 32'd0);
    wait_result("abort", 3, 17, 2'd0, 1'b1);
    handoff();

    // node1 must still hold class 1
    write_node(6'd0, mk_node(3'd0, 2'd0, 6'd1, 6'd2));
    run_sample("tbl_kept", 40'h0, 3, 2'd1, 1'b0);

    // write and accept in the same IDLE cycle: walk sees the new root
    cfg_addr  = 6'd0;
    cfg_wdata = mk_leaf(2'd3);
    cfg_we    = 1'b1;
    in_feat   = 40'h0;
    in_valid  = 1'b1;
    tick();
    cfg_we    = 1'b0;
    in_valid  = 1'b0;
    check_eq("samecyc_drop", {31'd0, cfg_drop}, 32'd0);
    wait_result("samecyc", 1, 2, 2'd3, 1'b0);
    handoff();

    // chain 0->1->2->3->leaf4, reset while visiting node3
    for (int unsigned n = 0; n < 4; n++)
      write_node(6'(n), mk_node(3'd0, 2'd3, 6'(n + 1), 6'(n + 1)));
    write_node(6'd4, mk_leaf(2'd2));
    start_sample(40'h0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_count", {16'd0, out_count}, 32'd0);
    check_eq("midrst_ready1", {31'd0, in_ready}, 32'd1);

    // rerun after reset (table retained), then hold backpressure
    start_sample(40'h0);
    wait_result("chain", 1, 6, 2'd2, 1'b0);
    in_valid = 1'b1;
    in_feat  = 40'hFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_class", {30'd0, out_class}, 32'd2);
      check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    check_eq("bp_count0", {16'd0, out_count}, 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_rel_ready", {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("bp_after_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_count1", {16'd0, out_count}, 32'd1);
    check_eq("bp_after_ready", {31'd0, in_ready}, 32'd1);

    // 40-node instance: address guard and bad child pointer
    b_cfg_addr  = 6'd40;
    b_cfg_wdata = mk_leaf(2'd1);
    b_cfg_we    = 1'b1;
    tick();
    check_eq("b_addr40_drop", {31'd0, b_cfg_drop}, 32'd1);
    b_cfg_addr  = 6'd0;
    b_cfg_wdata = mk_node(3'd0, 2'd0, 6'd63, 6'd1);
    tick();
    b_cfg_we    = 1'b0;
    check_eq("b_addr0_drop", {31'd0, b_cfg_drop}, 32'd0);
    b_in_feat  = 40'h0;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    k = 1;
    while (!b_out_valid && k < 50) begin
      tick();
      k++;
    end
    check_eq("b_badchild_lat", k, 32'd2);
    check_eq("b_badchild_err", {31'd0, b_out_err}, 32'd1);
    check_eq("b_badchild_class", {30'd0, b_out_class}, 32'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check_eq("b_count", {16'd0, b_out_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
